// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared types and constants for the multi-cycle RV32I control sequencer:
//   - mc_state_t : sequencer state encoding
//   - OP_*       : opcode[6:2] major-opcode values decoded in DECODE
//   - ALU_*      : ALUOp encodings driven toward the ALU control decoder
//   - SRCB_*     : ALU operand-B mux select encodings
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        WB_ALU = 4'd4,
        ADDR   = 4'd5,
        MEM_RD = 4'd6,
        WB_MEM = 4'd7,
        MEM_WR = 4'd8,
        BRANCH = 4'd9
    } mc_state_t;

    // opcode[6:2]; opcode[1:0] is always 2'b11 for 32-bit encodings
    localparam logic [4:0] OP_R  = 5'b01100;
    localparam logic [4:0] OP_I  = 5'b00100;
    localparam logic [4:0] OP_LD = 5'b00000;
    localparam logic [4:0] OP_ST = 5'b01000;
    localparam logic [4:0] OP_BR = 5'b11000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage : mc_ctrl_pkg

// File: rtl/mc_control_fsm_instret.sv
// -----------------------------------------------------------------------------
// mc_instret_counter
// Retired-instruction counter. Increments by one on every clock edge where
// i_en is high, wraps silently from all-ones to zero.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset, clears the count
//   i_en     in   retire strobe
//   o_count  out  current count (W bits)
// -----------------------------------------------------------------------------
module mc_instret_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // NOTE: sequential state is written with non-blocking (<=) assignments so
    // every flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : mc_instret_counter

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Multi-cycle control sequencer for the RV32I core. Steps the shared ALU, the
// unified single-ported memory, the register file and PC/IR/ALUOut through
// FETCH, DECODE, EXEC, MEM and WB states, counts retired instructions and
// flags unsupported opcodes.
// Ports:
//   clk, rst             clock / synchronous active-high reset
//   opcode[6:0]          IR[6:0], valid from DECODE onward
//   zf                   ALU zero flag (branch condition)
//   mem_ready            memory completes the outstanding request this cycle
//   pc_write, pc_src     PC load enable / PC source (0 = ALU, 1 = ALUOut)
//   iord                 memory address select (0 = PC, 1 = ALUOut)
//   mem_read, mem_write  memory requests
//   ir_write             IR load enable
//   alu_src_a/b, alu_op  ALU operand selects and ALUOp
//   reg_write, mem_to_reg register writeback enable / source
//   illegal              one-cycle pulse on an unsupported opcode
//   instret              retired-instruction count
//   pc_init              high while rst is high (PC loads RESET_PC)
// -----------------------------------------------------------------------------
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zf,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic             pc_init
);

    // The PC register itself consumes RESET_PC; it must be a word address.
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("mc_control_fsm: RESET_PC must be word aligned");
    end

    mc_state_t r_state;
    mc_state_t w_next_state;
    logic      w_retire;
    logic      w_unused_opcode_lsbs;

    // Only opcode[6:2] selects the instruction class.
    assign w_unused_opcode_lsbs = &{1'b0, opcode[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default before the case so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALU_ADD;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        illegal      = 1'b0;

        unique case (r_state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                // PC + imm lands in ALUOut as the speculative branch target
                alu_src_b = SRCB_IMM;
                case (opcode[6:2])
                    OP_R:          w_next_state = EXEC_R;
                    OP_I:          w_next_state = EXEC_I;
                    OP_LD, OP_ST:  w_next_state = ADDR;
                    OP_BR:         w_next_state = BRANCH;
                    default: begin
                        illegal      = 1'b1;
                        w_next_state = FETCH;
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_RS2;
                alu_op       = ALU_RTYPE;
                w_next_state = WB_ALU;
            end
            EXEC_I: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_op       = ALU_ITYPE;
                w_next_state = WB_ALU;
            end
            WB_ALU: begin
                reg_write    = 1'b1;
                w_retire     = 1'b1;
                w_next_state = FETCH;
            end
            ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                // opcode[5] separates store (0100011) from load (0000011)
                w_next_state = opcode[5] ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    w_next_state = WB_MEM;
                end
            end
            WB_MEM: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                w_retire     = 1'b1;
                w_next_state = FETCH;
            end
            MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = FETCH;
                end
            end
            BRANCH: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_RS2;
                alu_op       = ALU_SUB;
                pc_src       = 1'b1;
                pc_write     = zf;
                w_retire     = 1'b1;
                w_next_state = FETCH;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase

        // While reset is asserted nothing may reach memory, the register file
        // or the PC, so an interrupted store can never commit.
        if (rst) begin
            w_retire  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 1'b0;
            iord      = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = SRCB_RS2;
            alu_op    = ALU_ADD;
            reg_write = 1'b0;
            mem_to_reg = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign pc_init = rst;

    mc_instret_counter #(
        .W (CNT_W)
    ) u_instret (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_retire),
        .o_count (instret)
    );

endmodule : mc_control_fsm

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
// Directed bench for mc_control_fsm. Each clock cycle the bench applies
// mem_ready/zf, then compares the packed strobe vector against a hand-written
// per-state constant. Inputs change and outputs are sampled at the falling edge.
// Strobe vector layout:
//   {pc_write, pc_src, iord, mem_read, mem_write, ir_write,
//    alu_src_a, alu_src_b[1:0], alu_op[1:0], reg_write, mem_to_reg, illegal}
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

    localparam logic [13:0] V_IDLE   = 14'b000000_0_00_00_000;
    localparam logic [13:0] V_F_WAIT = 14'b000100_0_01_00_000;
    localparam logic [13:0] V_F_RDY  = 14'b100101_0_01_00_000;
    localparam logic [13:0] V_DEC    = 14'b000000_0_10_00_000;
    localparam logic [13:0] V_DEC_IL = 14'b000000_0_10_00_001;
    localparam logic [13:0] V_EXR    = 14'b000000_1_00_10_000;
    localparam logic [13:0] V_EXI    = 14'b000000_1_10_11_000;
    localparam logic [13:0] V_WBA    = 14'b000000_0_00_00_100;
    localparam logic [13:0] V_ADDR   = 14'b000000_1_10_00_000;
    localparam logic [13:0] V_MRD    = 14'b001100_0_00_00_000;
    localparam logic [13:0] V_WBM    = 14'b000000_0_00_00_110;
    localparam logic [13:0] V_MWR    = 14'b001010_0_00_00_000;
    localparam logic [13:0] V_BR_T   = 14'b110000_1_00_01_000;
    localparam logic [13:0] V_BR_NT  = 14'b010000_1_00_01_000;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        zf;
    logic        mem_ready;
    logic        pc_write, pc_src, iord, mem_read, mem_write, ir_write;
    logic        alu_src_a, reg_write, mem_to_reg, illegal, pc_init;
    logic [1:0]  alu_src_b, alu_op;
    logic [31:0] instret;
    logic [13:0] vec;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zf         (zf),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .instret    (instret),
        .pc_init    (pc_init)
    );

    assign vec = {pc_write, pc_src, iord, mem_read, mem_write, ir_write,
                  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: entered just after a falling edge, leaves at the next one.
    task automatic cyc(input string tag, input logic mr, input logic z, input logic [13:0] exp);
        mem_ready = mr;
        zf        = z;
        #1;
        check(tag, {18'd0, vec}, {18'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 7'b0000000;
        zf        = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_strobes", {18'd0, vec}, 32'd0);
        check("rst_pc_init", {31'd0, pc_init}, 32'd1);
        check("rst_instret", instret, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // add, zero wait: 4 cycles, mem_ready outside FETCH is ignored
        opcode = 7'b0110011;
        cyc("add_fetch",  1'b1, 1'b0, V_F_RDY);
        cyc("add_decode", 1'b1, 1'b0, V_DEC);
        cyc("add_exec",   1'b1, 1'b0, V_EXR);
        cyc("add_wb",     1'b1, 1'b0, V_WBA);
        check("add_instret", instret, 32'd1);

        // addi: 4 cycles
        opcode = 7'b0010011;
        cyc("addi_fetch",  1'b1, 1'b0, V_F_RDY);
        cyc("addi_decode", 1'b1, 1'b0, V_DEC);
        cyc("addi_exec",   1'b1, 1'b0, V_EXI);
        cyc("addi_wb",     1'b1, 1'b0, V_WBA);
        check("addi_instret", instret, 32'd2);

        // lw with 3 wait cycles in MEM_RD: 8 cycles total
        opcode = 7'b0000011;
        cyc("lw_fetch",  1'b1, 1'b0, V_F_RDY);
        cyc("lw_decode", 1'b1, 1'b0, V_DEC);
        cyc("lw_addr",   1'b1, 1'b0, V_ADDR);
        for (int i = 0; i < 3; i++) cyc("lw_memwait", 1'b0, 1'b0, V_MRD);
        cyc("lw_memrdy", 1'b1, 1'b0, V_MRD);
        cyc("lw_wb",     1'b1, 1'b0, V_WBM);
        check("lw_instret", instret, 32'd3);

        // beq taken, with one fetch wait cycle
        opcode = 7'b1100011;
        cyc("beqt_fwait",  1'b0, 1'b0, V_F_WAIT);
        cyc("beqt_fetch",  1'b1, 1'b0, V_F_RDY);
        cyc("beqt_decode", 1'b1, 1'b0, V_DEC);
        cyc("beqt_branch", 1'b1, 1'b1, V_BR_T);
        check("beqt_instret", instret, 32'd4);

        // beq not taken
        cyc("beqn_fetch",  1'b1, 1'b0, V_F_RDY);
        cyc("beqn_decode", 1'b1, 1'b0, V_DEC);
        cyc("beqn_branch", 1'b1, 1'b0, V_BR_NT);
        check("beqn_instret", instret, 32'd5);

        // illegal opcode: 2 cycles, single illegal pulse, no retire
        opcode = 7'b1111111;
        cyc("ill_fetch",  1'b1, 1'b0, V_F_RDY);
        cyc("ill_decode", 1'b1, 1'b0, V_DEC_IL);
        opcode = 7'b0110011;
        cyc("ill_back_fetch", 1'b0, 1'b0, V_F_WAIT);
        check("ill_instret", instret, 32'd5);

        // finish the pending add fetch to return to a clean boundary
        cyc("add2_fetch",  1'b1, 1'b0, V_F_RDY);
        cyc("add2_decode", 1'b1, 1'b0, V_DEC);
        cyc("add2_exec",   1'b1, 1'b0, V_EXR);
        cyc("add2_wb",     1'b1, 1'b0, V_WBA);
        check("add2_instret", instret, 32'd6);

        // counter wrap: preload all-ones, retire one sw
        force dut.u_instret.r_count = 32'hFFFF_FFFF;
        #1;
        release dut.u_instret.r_count;
        check("wrap_preload", instret, 32'hFFFF_FFFF);
        opcode = 7'b0100011;
        cyc("sw_fetch",  1'b1, 1'b0, V_F_RDY);
        cyc("sw_decode", 1'b1, 1'b0, V_DEC);
        cyc("sw_addr",   1'b1, 1'b0, V_ADDR);
        cyc("sw_memwr",  1'b1, 1'b0, V_MWR);
        check("wrap_instret", instret, 32'd0);

        // one more add so reset below clears a non-zero count
        opcode = 7'b0110011;
        cyc("add3_fetch",  1'b1, 1'b0, V_F_RDY);
        cyc("add3_decode", 1'b1, 1'b0, V_DEC);
        cyc("add3_exec",   1'b1, 1'b0, V_EXR);
        cyc("add3_wb",     1'b1, 1'b0, V_WBA);
        check("add3_instret", instret, 32'd1);

        // reset in the middle of a stalled store
        opcode = 7'b0100011;
        cyc("swr_fetch",  1'b1, 1'b0, V_F_RDY);
        cyc("swr_decode", 1'b1, 1'b0, V_DEC);
        cyc("swr_addr",   1'b1, 1'b0, V_ADDR);
        cyc("swr_memwr",  1'b0, 1'b0, V_MWR);
        rst = 1'b1;
        cyc("swr_in_rst", 1'b0, 1'b0, V_IDLE);
        rst = 1'b0;
        #1;
        check("swr_post_instret", instret, 32'd0);
        check("swr_post_memwr", {31'd0, mem_write}, 32'd0);
        for (int i = 0; i < 3; i++) cyc("swr_post_fetch", 1'b0, 1'b0, V_F_WAIT);
        check("swr_final_instret", instret, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_mc_control_fsm
